// File: rtl/regfile_wb_scheduler.sv
// Writeback scheduler: round-robin arbitration of NREQ result sources onto the single
// register-file write port, plus a busy scoreboard of destination registers reserved at issue.
module regfile_wb_scheduler #(
    parameter int NREQ  = 3,
    parameter int WIDTH = 32,
    parameter int DEPTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic [NREQ-1:0]       i_req_valid,
    output logic [NREQ-1:0]       o_req_ready,
    input  logic [NREQ*5-1:0]     i_req_rd_addr,
    input  logic [NREQ*WIDTH-1:0] i_req_rd_data,
    output logic                  o_rf_reg_write,
    output logic [4:0]            o_rf_rd_addr,
    output logic [WIDTH-1:0]      o_rf_rd_data,
    input  logic                  i_rsv_valid,
    input  logic [4:0]            i_rsv_addr,
    output logic                  o_rsv_ready,
    input  logic [4:0]            i_chk_rs1_addr,
    input  logic [4:0]            i_chk_rs2_addr,
    output logic                  o_chk_busy,
    output logic [DEPTH-1:0]      o_busy_mask
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]    r_rr_ptr;
    logic [DEPTH-1:0] r_busy;
    logic             r_reg_write;
    logic [4:0]       r_rd_addr;
    logic [WIDTH-1:0] r_rd_data;

    logic [PW-1:0]    w_winner;
    logic [PW-1:0]    w_next_ptr;
    logic             w_found;
    logic [NREQ-1:0]  w_grant;
    logic             w_transfer;
    logic [4:0]       w_win_addr;
    logic [WIDTH-1:0] w_win_data;
    logic             w_rsv_fire;
    logic [DEPTH-1:0] w_busy_nxt;
    int               w_idx;

    // Scan from the round-robin pointer; the first valid requester wins.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = 0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = int'(r_rr_ptr) + k;
            if (w_idx >= NREQ) begin
                w_idx = w_idx - NREQ;
            end
            if (!w_found && i_req_valid[w_idx]) begin
                w_found  = 1'b1;
                w_winner = PW'(w_idx);
            end
        end
    end

    always_comb begin
        w_grant    = '0;
        w_win_addr = '0;
        w_win_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_found && (w_winner == PW'(i))) begin
                w_grant[i] = i_reset_n;
                w_win_addr = i_req_rd_addr[i*5 +: 5];
                w_win_data = i_req_rd_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign o_req_ready = w_grant;
    assign w_transfer  = |(i_req_valid & w_grant);
    assign w_next_ptr  = (w_winner == PW'(NREQ - 1)) ? '0 : (w_winner + PW'(1));

    assign o_rsv_ready = i_reset_n & i_rsv_valid & ((i_rsv_addr == 5'd0) | ~r_busy[i_rsv_addr]);
    assign w_rsv_fire  = o_rsv_ready & (i_rsv_addr != 5'd0);

    // Clear from writeback first so a same-register reservation would win.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_transfer && (w_win_addr != 5'd0)) begin
            w_busy_nxt[w_win_addr] = 1'b0;
        end
        if (w_rsv_fire) begin
            w_busy_nxt[i_rsv_addr] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_rr_ptr    <= '0;
            r_busy      <= '0;
            r_reg_write <= 1'b0;
            r_rd_addr   <= '0;
            r_rd_data   <= '0;
        end else begin
            r_busy      <= w_busy_nxt;
            r_reg_write <= w_transfer & (w_win_addr != 5'd0);
            if (w_transfer) begin
                r_rr_ptr  <= w_next_ptr;
                r_rd_addr <= w_win_addr;
                r_rd_data <= w_win_data;
            end
        end
    end

    assign o_rf_reg_write = r_reg_write;
    assign o_rf_rd_addr   = r_rd_addr;
    assign o_rf_rd_data   = r_rd_data;
    assign o_busy_mask    = r_busy;
    assign o_chk_busy     = r_busy[i_chk_rs1_addr] | r_busy[i_chk_rs2_addr];

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed bench for regfile_wb_scheduler: stimulus pushes expected register-file writes,
// a negedge monitor pops and compares each write the DUT presents.
module tb_regfile_wb_scheduler;

    localparam int NREQ  = 3;
    localparam int WIDTH = 32;
    localparam int DEPTH = 32;

    logic                  clk;
    logic                  reset_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*5-1:0]     req_rd_addr;
    logic [NREQ*WIDTH-1:0] req_rd_data;
    logic                  rf_reg_write;
    logic [4:0]            rf_rd_addr;
    logic [WIDTH-1:0]      rf_rd_data;
    logic                  rsv_valid;
    logic [4:0]            rsv_addr;
    logic                  rsv_ready;
    logic [4:0]            chk_rs1_addr;
    logic [4:0]            chk_rs2_addr;
    logic                  chk_busy;
    logic [DEPTH-1:0]      busy_mask;

    int tests_run = 0;
    int tests_failed = 0;
    bit mon_en = 1'b0;
    logic [36:0] exp_q[$];

    regfile_wb_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .i_clk          (clk),
        .i_reset_n      (reset_n),
        .i_req_valid    (req_valid),
        .o_req_ready    (req_ready),
        .i_req_rd_addr  (req_rd_addr),
        .i_req_rd_data  (req_rd_data),
        .o_rf_reg_write (rf_reg_write),
        .o_rf_rd_addr   (rf_rd_addr),
        .o_rf_rd_data   (rf_rd_data),
        .i_rsv_valid    (rsv_valid),
        .i_rsv_addr     (rsv_addr),
        .o_rsv_ready    (rsv_ready),
        .i_chk_rs1_addr (chk_rs1_addr),
        .i_chk_rs2_addr (chk_rs2_addr),
        .o_chk_busy     (chk_busy),
        .o_busy_mask    (busy_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [4:0] a, input logic [WIDTH-1:0] d);
        req_rd_addr[i*5 +: 5]         = a;
        req_rd_data[i*WIDTH +: WIDTH] = d;
    endtask

    // Every presented write must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (mon_en && rf_reg_write === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", {27'd0, rf_rd_addr, rf_rd_data}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                logic [36:0] e;
                e = exp_q.pop_front();
                chk("wb_addr_data", {27'd0, rf_rd_addr, rf_rd_data}, {27'd0, e});
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
        $fatal(1);
    end

    logic [NREQ-1:0] grant_exp [4];

    initial begin
        reset_n      = 1'b0;
        req_valid    = 3'b111;
        req_rd_addr  = '0;
        req_rd_data  = '0;
        rsv_valid    = 1'b1;
        rsv_addr     = 5'd3;
        chk_rs1_addr = 5'd0;
        chk_rs2_addr = 5'd0;

        // 1: reset held two cycles with every request raised
        step();
        step();
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_rsv_ready", 64'(rsv_ready), 64'd0);
        chk("rst_reg_write", 64'(rf_reg_write), 64'd0);
        chk("rst_busy_mask", 64'(busy_mask), 64'd0);
        chk("rst_rd_addr", 64'(rf_rd_addr), 64'd0);
        req_valid = '0;
        rsv_valid = 1'b0;
        reset_n   = 1'b1;
        mon_en    = 1'b1;
        #1;

        // 2: single write, one cycle latency
        set_req(0, 5'd5, 32'hDEADBEEF);
        req_valid = 3'b001;
        #1;
        chk("t2_ready", 64'(req_ready), 64'b001);
        exp_q.push_back({5'd5, 32'hDEADBEEF});
        step();
        req_valid = '0;
        chk("t2_wr", 64'(rf_reg_write), 64'd1);
        step();
        chk("t2_wr_off", 64'(rf_reg_write), 64'd0);

        // 3: all three requesting from a fresh reset
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        set_req(0, 5'd10, 32'hA0A0_0000);
        set_req(1, 5'd11, 32'hA1A1_1111);
        set_req(2, 5'd12, 32'hA2A2_2222);
        req_valid = 3'b111;
        grant_exp[0] = 3'b001;
        grant_exp[1] = 3'b010;
        grant_exp[2] = 3'b100;
        grant_exp[3] = 3'b001;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("t3_grant%0d", k), 64'(req_ready), 64'(grant_exp[k]));
            case (k)
                0, 3:    exp_q.push_back({5'd10, 32'hA0A0_0000});
                1:       exp_q.push_back({5'd11, 32'hA1A1_1111});
                default: exp_q.push_back({5'd12, 32'hA2A2_2222});
            endcase
            step();
            if (k == 3) req_valid = '0;
            chk($sformatf("t3_wr%0d", k), 64'(rf_reg_write), 64'd1);
        end
        step();
        chk("t3_wr_off", 64'(rf_reg_write), 64'd0);

        // 4: reserve x7, hazard check, WAW refusal, writeback clears
        rsv_valid = 1'b1;
        rsv_addr  = 5'd7;
        #1;
        chk("t4_rsv_ok", 64'(rsv_ready), 64'd1);
        step();
        rsv_valid = 1'b0;
        chk("t4_busy7", 64'(busy_mask), 64'h80);
        chk_rs2_addr = 5'd7;
        #1;
        chk("t4_chk_rs2", 64'(chk_busy), 64'd1);
        chk_rs2_addr = 5'd0;
        chk_rs1_addr = 5'd7;
        rsv_valid    = 1'b1;
        #1;
        chk("t4_chk_rs1", 64'(chk_busy), 64'd1);
        chk("t4_rsv_waw", 64'(rsv_ready), 64'd0);
        rsv_valid = 1'b0;
        set_req(1, 5'd7, 32'h0000_0077);
        req_valid = 3'b010;
        #1;
        chk("t4_ready", 64'(req_ready), 64'b010);
        exp_q.push_back({5'd7, 32'h0000_0077});
        step();
        req_valid = '0;
        chk("t4_cleared", 64'(busy_mask), 64'd0);
        chk("t4_wr", 64'(rf_reg_write), 64'd1);
        #1;
        chk("t4_chk_free", 64'(chk_busy), 64'd0);
        chk_rs1_addr = 5'd0;

        // 5: x0 reservation and x0 writeback are accepted but inert
        rsv_valid = 1'b1;
        rsv_addr  = 5'd0;
        #1;
        chk("t5_rsv0", 64'(rsv_ready), 64'd1);
        step();
        rsv_valid = 1'b0;
        chk("t5_busy", 64'(busy_mask), 64'd0);
        set_req(2, 5'd0, 32'h1);
        req_valid = 3'b100;
        #1;
        chk("t5_ready", 64'(req_ready), 64'b100);
        step();
        req_valid = '0;
        chk("t5_no_wr", 64'(rf_reg_write), 64'd0);

        // set x4 busy, then write x4 while reserving x3 in the same cycle
        rsv_valid = 1'b1;
        rsv_addr  = 5'd4;
        step();
        chk("t5b_busy4", 64'(busy_mask), 64'h10);
        rsv_addr = 5'd3;
        set_req(0, 5'd4, 32'h4444_4444);
        req_valid = 3'b001;
        #1;
        chk("t5b_ready", 64'(req_ready), 64'b001);
        exp_q.push_back({5'd4, 32'h4444_4444});
        step();
        rsv_valid = 1'b0;
        req_valid = '0;
        chk("t5b_set_clr", 64'(busy_mask), 64'h08);

        // 6: reset mid-operation; pointer is 1 here, so a grant to 0 proves it returned to 0
        reset_n = 1'b0;
        set_req(0, 5'd3, 32'h3333_3333);
        set_req(1, 5'd9, 32'h9999_9999);
        req_valid = 3'b011;
        #1;
        chk("t6_gated", 64'(req_ready), 64'd0);
        step();
        chk("t6_busy", 64'(busy_mask), 64'd0);
        chk("t6_wr_cancel", 64'(rf_reg_write), 64'd0);
        reset_n = 1'b1;
        #1;
        chk("t6_regrant0", 64'(req_ready), 64'b001);
        exp_q.push_back({5'd3, 32'h3333_3333});
        step();
        req_valid = 3'b010;
        chk("t6_wr", 64'(rf_reg_write), 64'd1);
        #1;
        chk("t6_grant1", 64'(req_ready), 64'b010);
        exp_q.push_back({5'd9, 32'h9999_9999});
        step();
        req_valid = '0;
        step();
        step();

        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
